// File: rtl/read_manager_if.sv
// Read-path bundle between the read controller, the DQ/DQS pad capture and
// the external CRC block. The slave modport is the read manager itself.
interface read_manager_if #(
    parameter int pDRAM_SIZE = 4
);
    localparam int W = 2 * pDRAM_SIZE;

    // Controller side: command, latched-at-start configuration
    logic         enable_i;
    logic         rd_en_i;
    logic [1:0]   burstlength_i;
    logic [2:0]   precycle_i;
    logic [1:0]   postcycle_i;
    logic         dram_crc_en_i;
    logic [7:0]   pre_pattern_i;

    // Pad side. Handshake rule: dq_i/dqs_i are meaningful only in a cycle
    // where their own *_valid_i is high; there is no backpressure (no ready),
    // so every qualified sample is consumed or ignored in the cycle it appears.
    logic [W-1:0] dq_i;
    logic         dq_valid_i;
    logic [1:0]   dqs_i;
    logic         dqs_valid_i;

    // CRC block side
    logic [W-1:0] crc_code_i;
    logic [W-1:0] crc_data_o;
    logic         crc_enable_o;

    // Results and status
    logic [W-1:0] rd_data_o;
    logic         rd_data_valid_o;
    logic         rd_done_o;
    logic         preamble_err_o;
    logic         timeout_err_o;
    logic         crc_err_o;
    logic         busy_o;
    logic [2:0]   state_dbg_o;

    modport slave (
        input  enable_i, rd_en_i, burstlength_i, precycle_i, postcycle_i,
               dram_crc_en_i, pre_pattern_i, dq_i, dq_valid_i, dqs_i,
               dqs_valid_i, crc_code_i,
        output crc_data_o, crc_enable_o, rd_data_o, rd_data_valid_o,
               rd_done_o, preamble_err_o, timeout_err_o, crc_err_o, busy_o,
               state_dbg_o
    );

    modport master (
        output enable_i, rd_en_i, burstlength_i, precycle_i, postcycle_i,
               dram_crc_en_i, pre_pattern_i, dq_i, dq_valid_i, dqs_i,
               dqs_valid_i, crc_code_i,
        input  crc_data_o, crc_enable_o, rd_data_o, rd_data_valid_o,
               rd_done_o, preamble_err_o, timeout_err_o, crc_err_o, busy_o,
               state_dbg_o
    );
endinterface

// File: rtl/read_manager.sv
// DRAM read-return manager: waits for DQS, checks the read preamble, captures
// the data burst, feeds the CRC block (with BL8 padding), checks the received
// CRC word and times the postamble. All outputs are registered.
module read_manager #(
    parameter int pDRAM_SIZE = 4
) (
    input  logic          clk_i,
    input  logic          rst_i,
    read_manager_if.slave bus
);
    localparam int W = 2 * pDRAM_SIZE;

    typedef enum logic [2:0] {
        IDLE, WAIT_DQS, PREAMBLE, DATA, PAD, CRC, CHECK, POSTAMBLE
    } state_t;

    state_t       state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    // Latched configuration, stored as "index of the last cycle"
    logic [3:0]   data_last_q, data_last_d;
    logic [1:0]   pre_last_q, pre_last_d;
    logic [1:0]   post_last_q, post_last_d;
    logic         crc_on_q, crc_on_d;
    logic         bl8_q, bl8_d;
    logic [W-1:0] rx_crc_q, rx_crc_d;

    logic [W-1:0] rd_data_q, rd_data_d, crc_data_q, crc_data_d;
    logic         rd_valid_q, rd_valid_d, crc_en_q, crc_en_d;
    logic         done_q, done_d, perr_q, perr_d, terr_q, terr_d;
    logic         cerr_q, cerr_d, busy_q, busy_d;

    logic         beat;
    logic [1:0]   exp_dqs;

    // A data/pad/crc cycle counts only with both qualifiers and a 10 strobe
    assign beat = bus.dq_valid_i && bus.dqs_valid_i && (bus.dqs_i == 2'b10);

    // Expected preamble strobe pair for preamble cycle cnt_q (MSB pair first)
    always_comb begin
        case (cnt_q[1:0])
            2'd0:    exp_dqs = bus.pre_pattern_i[7:6];
            2'd1:    exp_dqs = bus.pre_pattern_i[5:4];
            2'd2:    exp_dqs = bus.pre_pattern_i[3:2];
            default: exp_dqs = bus.pre_pattern_i[1:0];
        endcase
    end

    // Next-state, counter, config latch and registered-output values
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        data_last_d = data_last_q;
        pre_last_d  = pre_last_q;
        post_last_d = post_last_q;
        crc_on_d    = crc_on_q;
        bl8_d       = bl8_q;
        rx_crc_d    = rx_crc_q;
        rd_data_d   = '0;
        crc_data_d  = '0;
        rd_valid_d  = 1'b0;
        crc_en_d    = 1'b0;
        done_d      = 1'b0;
        perr_d      = 1'b0;
        terr_d      = 1'b0;
        cerr_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.rd_en_i) begin
                    state_d  = WAIT_DQS;
                    cnt_d    = '0;
                    crc_on_d = bus.dram_crc_en_i;
                    bl8_d    = (bus.burstlength_i == 2'b01);
                    case (bus.burstlength_i)
                        2'b01:   data_last_d = 4'd3;
                        2'b10:   data_last_d = 4'd15;
                        default: data_last_d = 4'd7;
                    endcase
                    if (bus.precycle_i == 3'd0 || bus.precycle_i > 3'd4)
                        pre_last_d = 2'd3;
                    else
                        pre_last_d = 2'(bus.precycle_i - 3'd1);
                    post_last_d = (bus.postcycle_i == 2'd0) ? 2'd0 : bus.postcycle_i - 2'd1;
                end
            end
            WAIT_DQS: begin
                // The first qualified strobe is already preamble cycle 0
                if (bus.dqs_valid_i) begin
                    if (bus.dqs_i == bus.pre_pattern_i[7:6]) begin
                        if (pre_last_q == 2'd0) begin
                            state_d = DATA;
                            cnt_d   = '0;
                        end else begin
                            state_d = PREAMBLE;
                            cnt_d   = 4'd1;
                        end
                    end else begin
                        state_d = IDLE;
                        perr_d  = 1'b1;
                    end
                end else if (cnt_q == 4'd15) begin
                    state_d = IDLE;
                    terr_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            PREAMBLE: begin
                if (bus.dqs_valid_i && bus.dqs_i == exp_dqs) begin
                    if (cnt_q[1:0] == pre_last_q) begin
                        state_d = DATA;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end else begin
                    state_d = IDLE;
                    perr_d  = 1'b1;
                end
            end
            DATA: begin
                if (beat) begin
                    rd_data_d  = bus.dq_i;
                    rd_valid_d = 1'b1;
                    if (crc_on_q) begin
                        crc_data_d = bus.dq_i;
                        crc_en_d   = 1'b1;
                    end
                    if (cnt_q == data_last_q) begin
                        cnt_d = '0;
                        if (bl8_q && crc_on_q) state_d = PAD;
                        else if (crc_on_q)     state_d = CRC;
                        else                   state_d = POSTAMBLE;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            PAD: begin
                // BL8 is padded to BL16 length with all-ones for the CRC block
                if (beat) begin
                    crc_data_d = '1;
                    crc_en_d   = 1'b1;
                    if (cnt_q[1:0] == 2'd3) begin
                        state_d = CRC;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            CRC: begin
                if (beat) begin
                    rx_crc_d = bus.dq_i;
                    state_d  = CHECK;
                end
            end
            CHECK: begin
                cerr_d  = (bus.crc_code_i != rx_crc_q);
                state_d = POSTAMBLE;
                cnt_d   = '0;
            end
            POSTAMBLE: begin
                if (cnt_q[1:0] == post_last_q) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Disable wins over everything: quiet return to IDLE, no pulses
        if (!bus.enable_i) begin
            state_d    = IDLE;
            cnt_d      = '0;
            rd_data_d  = '0;
            crc_data_d = '0;
            rd_valid_d = 1'b0;
            crc_en_d   = 1'b0;
            done_d     = 1'b0;
            perr_d     = 1'b0;
            terr_d     = 1'b0;
            cerr_d     = 1'b0;
        end

        busy_d = (state_d != IDLE);
    end

    // State, counter and latched configuration
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            data_last_q <= '0;
            pre_last_q  <= '0;
            post_last_q <= '0;
            crc_on_q    <= 1'b0;
            bl8_q       <= 1'b0;
            rx_crc_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            data_last_q <= data_last_d;
            pre_last_q  <= pre_last_d;
            post_last_q <= post_last_d;
            crc_on_q    <= crc_on_d;
            bl8_q       <= bl8_d;
            rx_crc_q    <= rx_crc_d;
        end
    end

    // Registered outputs
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rd_data_q  <= '0;
            crc_data_q <= '0;
            rd_valid_q <= 1'b0;
            crc_en_q   <= 1'b0;
            done_q     <= 1'b0;
            perr_q     <= 1'b0;
            terr_q     <= 1'b0;
            cerr_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            rd_data_q  <= rd_data_d;
            crc_data_q <= crc_data_d;
            rd_valid_q <= rd_valid_d;
            crc_en_q   <= crc_en_d;
            done_q     <= done_d;
            perr_q     <= perr_d;
            terr_q     <= terr_d;
            cerr_q     <= cerr_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.rd_data_o       = rd_data_q;
    assign bus.rd_data_valid_o = rd_valid_q;
    assign bus.crc_data_o      = crc_data_q;
    assign bus.crc_enable_o    = crc_en_q;
    assign bus.rd_done_o       = done_q;
    assign bus.preamble_err_o  = perr_q;
    assign bus.timeout_err_o   = terr_q;
    assign bus.crc_err_o       = cerr_q;
    assign bus.busy_o          = busy_q;
    assign bus.state_dbg_o     = state_q;
endmodule

// File: doc/read_manager.md
READ_MANAGER -- requirements
Module: read_manager

Interface
REQ-001 Parameter pDRAM_SIZE, default 4, DRAM device width; DQ word per clock is 2*pDRAM_SIZE bits (two beats).
REQ-002 clk_i  in  1  sole clock; all state updates on rising edge.
REQ-003 rst_i  in  1  reset, asynchronous assert, active-low.
REQ-004 enable_i  in  1  block enable; low forces IDLE synchronously.
REQ-005 rd_en_i  in  1  one-cycle read-command pulse from controller.
REQ-006 burstlength_i  in  2  00=BL16 (8 data cycles), 01=BL8 (4 data + 4 pad cycles), 10=BL32 (16 data cycles), 11=treated as 00.
REQ-007 precycle_i  in  3  read-preamble length in cycles; 0 or >4 treated as 4.
REQ-008 postcycle_i  in  2  postamble length in cycles; 0 treated as 1.
REQ-009 dram_crc_en_i  in  1  DRAM appends one CRC word after the data.
REQ-010 pre_pattern_i  in  8  expected DQS preamble, 2 bits/cycle, MSB pair first.
REQ-011 dq_i  in  2*pDRAM_SIZE  read data from pads; dq_valid_i  in  1  qualifies dq_i.
REQ-012 dqs_i  in  2  strobe sample pair; dqs_valid_i  in  1  qualifies dqs_i.
REQ-013 crc_code_i  in  2*pDRAM_SIZE  CRC computed by external CRC block over crc_data_o.
REQ-014 rd_data_o  out  2*pDRAM_SIZE  captured read data; rd_data_valid_o  out  1  qualifier.
REQ-015 crc_data_o  out  2*pDRAM_SIZE  words fed to CRC block; crc_enable_o  out  1  qualifier.
REQ-016 rd_done_o, preamble_err_o, timeout_err_o, crc_err_o  out  1 each  one-cycle status pulses; busy_o  out  1  high when not IDLE.

Function
REQ-017 States: IDLE, WAIT_DQS, PREAMBLE, DATA, PAD, CRC, CHECK, POSTAMBLE; all outputs registered.
REQ-018 IDLE -> WAIT_DQS on rd_en_i=1 with enable_i=1; burstlength_i, precycle_i, postcycle_i, dram_crc_en_i latched that cycle; rd_en_i ignored in any other state.
REQ-019 WAIT_DQS: first cycle with dqs_valid_i=1 is preamble cycle 0 (-> PREAMBLE evaluation); 16 cycles without dqs_valid_i -> timeout_err_o pulse, IDLE.
REQ-020 PREAMBLE: cycle k compares dqs_i to pre_pattern_i[7-2k:6-2k]; mismatch or dqs_valid_i=0 -> preamble_err_o pulse, IDLE; all latched-length cycles matched -> DATA.
REQ-021 DATA: a cycle counts only when dq_valid_i=1 and dqs_valid_i=1 and dqs_i=2'b10; non-counting cycles stall the beat counter without error.
REQ-022 Each counted DATA cycle: rd_data_o<=dq_i, rd_data_valid_o=1, crc_data_o<=dq_i, crc_enable_o=1 (crc only if CRC latched), all one cycle after capture.
REQ-023 After last data cycle: BL8 with CRC -> PAD; else CRC latched -> CRC; else -> POSTAMBLE.
REQ-024 PAD: 4 counted cycles; crc_data_o<=all-ones regardless of dq_i, crc_enable_o=1, rd_data_valid_o=0; then -> CRC. BL8 without CRC skips PAD and its pad cycles are not consumed.
REQ-025 CRC: one counted cycle; dq_i stored as received CRC, crc_enable_o=0, rd_data_valid_o=0; -> CHECK.
REQ-026 CHECK: one cycle; crc_code_i compared to stored word; mismatch -> crc_err_o pulse; -> POSTAMBLE.
REQ-027 POSTAMBLE: latched postcycle count of cycles, dqs_i not checked; final cycle -> rd_done_o pulse, IDLE.
REQ-028 enable_i=0 in any state: next cycle IDLE, all outputs 0, no done/error pulse.
REQ-029 Error pulses and rd_done_o are mutually exclusive within one transaction; a transaction ends with exactly one of rd_done_o, preamble_err_o, timeout_err_o (crc_err_o precedes rd_done_o).

Reset
REQ-030 rst_i=0 asynchronously forces IDLE, clears counters and latched config, all outputs 0; applies mid-transaction with no done/error pulse.

Verification
REQ-031 BL16, no CRC, precycle 2, pre_pattern 8'b10101000, dqs 10,10 then 8 words A5 -> rd_data_valid_o 8 cycles data A5, rd_done_o after 1 postamble cycle.
REQ-032 BL8, CRC on, data 4x A5, crc_code_i=8'h3C, rx CRC 8'h3C -> crc_data_o A5x4 then FFx4, no crc_err_o, rd_done_o.
REQ-033 Same as REQ-032 with rx CRC 8'h3D -> crc_err_o pulse in CHECK, then rd_done_o.
REQ-034 Preamble cycle 1 dqs_i=2'b00 -> preamble_err_o pulse, busy_o low next cycle, no rd_data_valid_o.
REQ-035 rd_en_i with dqs_valid_i held 0 -> timeout_err_o after 16 cycles; rst_i low mid-DATA -> outputs 0 immediately.
REQ-036 dq_valid_i low 3 cycles mid-DATA (BL16) -> exactly 8 valid words still delivered, order preserved.
